mem_req_issuer: RTL and testbench
=================================

// Module: mem_req_issuer
// PURPOSE
//  Downstream consumer of the merged two-queue request FIFO (fall-through, round-robin).
//  Pops one request at a time and issues it as a single-beat AXI4-Lite read or write.
//  Returns the read data or write completion to the core with a one-cycle pulse. One transaction outstanding.
// PARAMETERS
//  ADDR_WIDTH  32  address width of requests and AXI address channels
//  DATA_WIDTH  32  data width; wstrb width = DATA_WIDTH/8
// PORTS
//  clk_i         in   1     clock, all logic on rising edge
//  rst_ni        in   1     synchronous reset, active-low
//  req_empty_i   in   1     upstream queue empty; req_* fields valid when 0 (fall-through)
//  req_pop_o     out  1     pop head of upstream queue
//  req_we_i      in   1     1 = write, 0 = read
//  req_addr_i    in   AW    request address
//  req_wdata_i   in   DW    write data
//  req_wstrb_i   in   DW/8  write byte strobes
//  m_araddr_o    out  AW    AR address
//  m_arvalid_o   out  1     AR valid
//  m_arready_i   in   1     AR ready
//  m_rdata_i     in   DW    R data
//  m_rresp_i     in   2     R response
//  m_rvalid_i    in   1     R valid
//  m_rready_o    out  1     R ready
//  m_awaddr_o    out  AW    AW address
//  m_awvalid_o   out  1     AW valid
//  m_awready_i   in   1     AW ready
//  m_wdata_o     out  DW    W data
//  m_wstrb_o     out  DW/8  W strobes
//  m_wvalid_o    out  1     W valid
//  m_wready_i    in   1     W ready
//  m_bresp_i     in   2     B response
//  m_bvalid_i    in   1     B valid
//  m_bready_o    out  1     B ready
//  resp_valid_o  out  1     one-cycle completion pulse
//  resp_we_o     out  1     completed request was a write
//  resp_rdata_o  out  DW    read data; held until the next completion
//  resp_err_o    out  1     xRESP != 2'b00 (SLVERR/DECERR)
// BEHAVIOUR
//  Reset (rst_ni=0 at clk edge):
//   - FSM -> IDLE.
//   - All valid/ready outputs, req_pop_o, resp_* = 0; address/data regs = 0.
//   - Applies mid-transaction: any in-flight AXI beat is abandoned.
//  FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
//  IDLE:
//   - req_pop_o = ~req_empty_i, combinational, IDLE only.
//   - On pop: latch we/addr/wdata/wstrb; go to RD_ADDR (we=0) or WR_REQ (we=1).
//  RD_ADDR:
//   - m_arvalid_o=1, m_araddr_o stable until m_arready_i; then RD_DATA.
//  RD_DATA:
//   - m_rready_o=1; on m_rvalid_i: latch rdata and error, pulse resp, go to IDLE.
//  WR_REQ:
//   - AW and W driven independently; each valid drops after its own handshake (aw_done/w_done flags).
//   - Either order or the same cycle is legal. When both are done, go to WR_RESP.
//  WR_RESP:
//   - m_bready_o=1; on m_bvalid_i: pulse resp (resp_we_o=1), go to IDLE.
//   - resp_rdata_o is unchanged by writes.
//  Timing:
//   - Valids assert the cycle after the pop; each is held until its ready, with payload stable (AXI rule).
//   - Zero-wait slave: read = 3 cycles pop->resp_valid_o; write = 3 cycles.
//   - resp_valid_o is registered and asserts the cycle after the R/B handshake.
//   - Next pop is possible in the same cycle resp_valid_o is high (FSM already in IDLE).
//  Boundaries:
//   - req_empty_i=1 in IDLE: no pop, stay in IDLE.
//   - Upstream flush while not IDLE has no effect on the latched request.
//   - rvalid/bvalid arriving in a state that does not accept it is ignored; ready stays 0.
// TESTING
//  - Read 0x1000, slave arready/rvalid immediate, rdata=0xDEADBEEF
//    -> resp_valid_o 3 cycles after pop, resp_rdata_o=0xDEADBEEF, err=0.
//  - Write 0x2004/0x12345678/strb 0xF, wready 2 cycles before awready
//    -> each valid drops on its own handshake; one resp pulse with we=1.
//  - Read with rresp=2'b10 -> resp_err_o=1; write with bresp=2'b11 -> resp_err_o=1.
//  - 4 queued requests alternating R/W, slave stalls 0-3 cycles at random
//    -> exactly 4 pops and 4 resps, in order; no payload change while valid && !ready.
//  - rst_ni=0 while in RD_DATA -> next cycle IDLE, all outputs 0; a fresh request completes normally.
//  - req_empty_i=1 for 10 cycles -> req_pop_o and all valids stay 0.

Source files
------------

// File: rtl/mem_req_issuer.sv
`default_nettype none
// ============================================================================
// Module : mem_req_issuer
// Pops requests from a fall-through request FIFO and issues each one as a
// single-beat AXI4-Lite read or write, one transaction outstanding.
// Rev    : 1.0  initial release
// ============================================================================

module mem_req_issuer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // upstream request queue
  input  logic                    req_empty_i,
  output logic                    req_pop_o,
  input  logic                    req_we_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb_i,
  // AXI4-Lite read channels
  output logic [ADDR_WIDTH-1:0]   m_araddr_o,
  output logic                    m_arvalid_o,
  input  logic                    m_arready_i,
  input  logic [DATA_WIDTH-1:0]   m_rdata_i,
  input  logic [1:0]              m_rresp_i,
  input  logic                    m_rvalid_i,
  output logic                    m_rready_o,
  // AXI4-Lite write channels
  output logic [ADDR_WIDTH-1:0]   m_awaddr_o,
  output logic                    m_awvalid_o,
  input  logic                    m_awready_i,
  output logic [DATA_WIDTH-1:0]   m_wdata_o,
  output logic [DATA_WIDTH/8-1:0] m_wstrb_o,
  output logic                    m_wvalid_o,
  input  logic                    m_wready_i,
  input  logic [1:0]              m_bresp_i,
  input  logic                    m_bvalid_i,
  output logic                    m_bready_o,
  // completion to the core
  output logic                    resp_valid_o,
  output logic                    resp_we_o,
  output logic [DATA_WIDTH-1:0]   resp_rdata_o,
  output logic                    resp_err_o
);

  localparam int c_STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_RESP = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;

  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [c_STRB_WIDTH-1:0] r_wstrb;
  logic                    r_aw_done;
  logic                    r_w_done;
  logic                    r_resp_valid;
  logic                    r_resp_we;
  logic [DATA_WIDTH-1:0]   r_resp_rdata;
  logic                    r_resp_err;

  logic                    w_aw_fire;
  logic                    w_w_fire;
  logic                    w_r_fire;
  logic                    w_b_fire;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    req_pop_o    = 1'b0;
    m_arvalid_o  = 1'b0;
    m_rready_o   = 1'b0;
    m_awvalid_o  = 1'b0;
    m_wvalid_o   = 1'b0;
    m_bready_o   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Gated by reset so a request is never consumed on a resetting edge.
        req_pop_o = ~req_empty_i & rst_ni;
        if (req_pop_o) begin
          w_state_next = req_we_i ? S_WR_REQ : S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        m_arvalid_o = 1'b1;
        if (m_arready_i) begin
          w_state_next = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        m_rready_o = 1'b1;
        if (m_rvalid_i) begin
          w_state_next = S_IDLE;
        end
      end
      S_WR_REQ: begin
        m_awvalid_o = ~r_aw_done;
        m_wvalid_o  = ~r_w_done;
        if ((r_aw_done | m_awready_i) & (r_w_done | m_wready_i)) begin
          w_state_next = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        m_bready_o = 1'b1;
        if (m_bvalid_i) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign w_aw_fire = m_awvalid_o & m_awready_i;
  assign w_w_fire  = m_wvalid_o  & m_wready_i;
  assign w_r_fire  = m_rready_o  & m_rvalid_i;
  assign w_b_fire  = m_bready_o  & m_bvalid_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_we    <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      if (req_pop_o) begin
        r_addr    <= req_addr_i;
        r_wdata   <= req_wdata_i;
        r_wstrb   <= req_wstrb_i;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (w_aw_fire) begin
        r_aw_done <= 1'b1;
      end
      if (w_w_fire) begin
        r_w_done <= 1'b1;
      end
      if (w_r_fire) begin
        r_resp_valid <= 1'b1;
        r_resp_we    <= 1'b0;
        r_resp_rdata <= m_rdata_i;
        r_resp_err   <= |m_rresp_i;
      end
      // Write completions leave the last read data visible to the core.
      if (w_b_fire) begin
        r_resp_valid <= 1'b1;
        r_resp_we    <= 1'b1;
        r_resp_err   <= |m_bresp_i;
      end
    end
  end

  assign m_araddr_o   = r_addr;
  assign m_awaddr_o   = r_addr;
  assign m_wdata_o    = r_wdata;
  assign m_wstrb_o    = r_wstrb;
  assign resp_valid_o = r_resp_valid;
  assign resp_we_o    = r_resp_we;
  assign resp_rdata_o = r_resp_rdata;
  assign resp_err_o   = r_resp_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_req_issuer.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_req_issuer
// Scoreboard bench: upstream queue model, AXI4-Lite slave with per-channel
// stalls, and a completion monitor checking against expected responses.
// Rev    : 1.0  initial release
// ============================================================================

module tb_mem_req_issuer;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          req_empty_i, req_pop_o, req_we_i;
  logic [AW-1:0] req_addr_i;
  logic [DW-1:0] req_wdata_i;
  logic [SW-1:0] req_wstrb_i;
  logic [AW-1:0] m_araddr_o, m_awaddr_o;
  logic          m_arvalid_o, m_arready_i, m_rvalid_i, m_rready_o;
  logic [DW-1:0] m_rdata_i, m_wdata_o;
  logic [1:0]    m_rresp_i, m_bresp_i;
  logic          m_awvalid_o, m_awready_i, m_wvalid_o, m_wready_i;
  logic [SW-1:0] m_wstrb_o;
  logic          m_bvalid_i, m_bready_o;
  logic          resp_valid_o, resp_we_o, resp_err_o;
  logic [DW-1:0] resp_rdata_o;

  mem_req_issuer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_empty_i(req_empty_i), .req_pop_o(req_pop_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
    .m_araddr_o(m_araddr_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
    .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i), .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
    .m_awaddr_o(m_awaddr_o), .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
    .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o), .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
    .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o),
    .resp_valid_o(resp_valid_o), .resp_we_o(resp_we_o),
    .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o)
  );

  always #5 clk_i = ~clk_i;

  // data is the write data for writes and the slave's read data for reads
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [1:0]    resp;
    int            ar_st, r_st, aw_st, w_st, b_st;
    int            lat;
  } txn_t;

  typedef struct {
    logic          we;
    logic [DW-1:0] rdata;
    logic          err;
    int            pop_cyc;
    int            lat;
  } exp_t;

  txn_t          up_q[$];
  txn_t          plan_q[$];
  exp_t          exp_q[$];
  int            checks = 0;
  int            failures = 0;
  int            cycle = 0;
  int            n_pops = 0;
  int            n_resps = 0;
  int            n_aborted = 0;
  logic [DW-1:0] model_rdata = '0;

  always @(posedge clk_i) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic txn_t mk(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                              input logic [SW-1:0] strb, input logic [1:0] resp, input int lat);
    txn_t t;
    t.we = we; t.addr = addr; t.data = data; t.strb = strb; t.resp = resp;
    t.ar_st = 0; t.r_st = 0; t.aw_st = 0; t.w_st = 0; t.b_st = 0;
    t.lat = lat;
    return t;
  endfunction

  function automatic txn_t mk_rand(input logic we);
    txn_t t;
    t = mk(we, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom, SW'($urandom_range(0, (1 << SW) - 1)),
           ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, 0);
    t.ar_st = $urandom_range(0, 3); t.r_st = $urandom_range(0, 3);
    t.aw_st = $urandom_range(0, 3); t.w_st = $urandom_range(0, 3); t.b_st = $urandom_range(0, 3);
    return t;
  endfunction

  // Upstream fall-through queue; each observed pop becomes a slave plan and an expectation.
  initial begin : upstream
    txn_t t;
    exp_t e;
    req_empty_i = 1'b1; req_we_i = 1'b0; req_addr_i = '0; req_wdata_i = '0; req_wstrb_i = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) model_rdata = '0;
      if (up_q.size() != 0) begin
        t = up_q[0];
        req_empty_i = 1'b0; req_we_i = t.we; req_addr_i = t.addr;
        req_wdata_i = t.we ? t.data : $urandom; req_wstrb_i = t.strb;
      end else begin
        req_empty_i = 1'b1; req_addr_i = $urandom; req_wdata_i = $urandom;
      end
      #1;
      if (req_pop_o && !req_empty_i) begin
        void'(up_q.pop_front());
        n_pops++;
        plan_q.push_back(t);
        if (!t.we) model_rdata = t.data;
        e.we = t.we; e.rdata = model_rdata; e.err = (t.resp != 2'b00);
        e.pop_cyc = cycle; e.lat = t.lat;
        exp_q.push_back(e);
      end
    end
  end

  // AXI4-Lite slave: readies/valids gated by per-transaction stall counts.
  initial begin : slave
    txn_t          cur;
    int            ar_c, r_c, aw_c, w_c, b_c;
    bit            ar_d, aw_d, w_d, ar_h, aw_h, w_h, have;
    logic [AW-1:0] ar_p, aw_p;
    logic [DW-1:0] wd_p;
    logic [SW-1:0] ws_p;
    ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
    ar_d = 0; aw_d = 0; w_d = 0; ar_h = 0; aw_h = 0; w_h = 0;
    m_arready_i = 0; m_rvalid_i = 0; m_rdata_i = '0; m_rresp_i = '0;
    m_awready_i = 0; m_wready_i = 0; m_bvalid_i = 0; m_bresp_i = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        plan_q.delete();
        ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
        ar_d = 0; aw_d = 0; w_d = 0; ar_h = 0; aw_h = 0; w_h = 0;
        m_arready_i = 0; m_rvalid_i = 0; m_awready_i = 0; m_wready_i = 0; m_bvalid_i = 0;
      end else begin
        if (ar_h) check("ar_hold", {m_arvalid_o, m_araddr_o}, {1'b1, ar_p});
        if (aw_h) check("aw_hold", {m_awvalid_o, m_awaddr_o}, {1'b1, aw_p});
        if (w_h)  check("w_hold", {m_wvalid_o, m_wdata_o, m_wstrb_o}, {1'b1, wd_p, ws_p});
        have = (plan_q.size() != 0);
        if (!have) begin
          check("idle_valids", {m_arvalid_o, m_awvalid_o, m_wvalid_o}, 3'b000);
          m_arready_i = 0; m_rvalid_i = 0; m_awready_i = 0; m_wready_i = 0; m_bvalid_i = 0;
          m_rdata_i = $urandom; m_rresp_i = '0; m_bresp_i = '0;
        end else begin
          cur = plan_q[0];
          m_arready_i = m_arvalid_o && (ar_c >= cur.ar_st);
          m_rvalid_i  = ar_d && (r_c >= cur.r_st);
          m_rdata_i   = m_rvalid_i ? cur.data : $urandom;
          m_rresp_i   = m_rvalid_i ? cur.resp : 2'b00;
          m_awready_i = m_awvalid_o && (aw_c >= cur.aw_st);
          m_wready_i  = m_wvalid_o && (w_c >= cur.w_st);
          m_bvalid_i  = aw_d && w_d && (b_c >= cur.b_st);
          m_bresp_i   = m_bvalid_i ? cur.resp : 2'b00;
          if (ar_d) check("arvalid_dropped", m_arvalid_o, 0);
          if (aw_d) check("awvalid_dropped", m_awvalid_o, 0);
          if (w_d)  check("wvalid_dropped", m_wvalid_o, 0);
        end
        #1;
        ar_h = m_arvalid_o && !m_arready_i; ar_p = m_araddr_o;
        aw_h = m_awvalid_o && !m_awready_i; aw_p = m_awaddr_o;
        w_h  = m_wvalid_o && !m_wready_i;   wd_p = m_wdata_o; ws_p = m_wstrb_o;
        if (have) begin
          if (ar_d && !m_rvalid_i) r_c++;
          if (aw_d && w_d && !m_bvalid_i) b_c++;
          if (m_arvalid_o && m_arready_i) begin
            check("araddr", m_araddr_o, cur.addr);
            ar_d = 1;
          end else if (m_arvalid_o) ar_c++;
          if (m_awvalid_o && m_awready_i) begin
            check("awaddr", m_awaddr_o, cur.addr);
            aw_d = 1;
          end else if (m_awvalid_o) aw_c++;
          if (m_wvalid_o && m_wready_i) begin
            check("wdata_wstrb", {m_wdata_o, m_wstrb_o}, {cur.data, cur.strb});
            w_d = 1;
          end else if (m_wvalid_o) w_c++;
          if ((m_rvalid_i && m_rready_o) || (m_bvalid_i && m_bready_o)) begin
            void'(plan_q.pop_front());
            ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
            ar_d = 0; aw_d = 0; w_d = 0; ar_h = 0; aw_h = 0; w_h = 0;
          end
        end
      end
    end
  end

  // Completion monitor: pops the oldest expectation for every resp_valid_o pulse.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      #2;
      if (!rst_ni) begin
        exp_q.delete();
      end else if (resp_valid_o) begin
        n_resps++;
        if (exp_q.size() == 0) begin
          check("resp_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("resp_we", resp_we_o, e.we);
          check("resp_rdata", resp_rdata_o, e.rdata);
          check("resp_err", resp_err_o, e.err);
          if (e.lat != 0) check("resp_latency", cycle - e.pop_cyc, e.lat);
        end
      end
    end
  end

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((up_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      @(negedge clk_i);
      #3;
      n++;
    end
    check("drain_in_time", (n < budget), 1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : main
    txn_t t;
    int   n;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    @(negedge clk_i);
    #3;
    check("rst_ctrl", {req_pop_o, m_arvalid_o, m_rready_o, m_awvalid_o, m_wvalid_o, m_bready_o,
                       resp_valid_o, resp_we_o, resp_err_o}, 9'd0);
    check("rst_rdata", resp_rdata_o, 0);
    check("rst_addr", {m_araddr_o, m_awaddr_o}, 0);
    check("rst_wpayload", {m_wdata_o, m_wstrb_o}, 0);

    // Idle with an empty queue.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      #3;
      check("empty_no_activity", {req_pop_o, m_arvalid_o, m_awvalid_o, m_wvalid_o, resp_valid_o}, 5'd0);
    end

    // Zero-wait read, then write with W accepted two cycles ahead of AW.
    up_q.push_back(mk(1'b0, 32'h1000, 32'hDEAD_BEEF, 4'h0, 2'b00, 3));
    drain(50);
    t = mk(1'b1, 32'h2004, 32'h1234_5678, 4'hF, 2'b00, 5);
    t.aw_st = 2;
    up_q.push_back(t);
    drain(50);

    // Error responses.
    up_q.push_back(mk(1'b0, 32'h3000, 32'hA5A5_0F0F, 4'h0, 2'b10, 3));
    up_q.push_back(mk(1'b1, 32'h3004, 32'h0BAD_F00D, 4'h3, 2'b11, 3));
    drain(50);

    // Four queued alternating requests, then a longer random mix.
    for (int i = 0; i < 4; i++) up_q.push_back(mk_rand(i[0]));
    drain(200);
    for (int i = 0; i < 40; i++) up_q.push_back(mk_rand(1'($urandom_range(0, 1))));
    drain(2000);

    // Reset while waiting on read data abandons the read.
    t = mk(1'b0, 32'h4000, 32'h7777_7777, 4'h0, 2'b00, 0);
    t.r_st = 30;
    up_q.push_back(t);
    n = 0;
    while (!m_rready_o && n < 50) begin
      @(negedge clk_i);
      #3;
      n++;
    end
    check("reached_rd_data", m_rready_o, 1);
    @(posedge clk_i);
    #2 rst_ni = 1'b0;
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    n_aborted++;
    @(negedge clk_i);
    #3;
    check("midrst_ctrl", {req_pop_o, m_arvalid_o, m_rready_o, m_awvalid_o, m_wvalid_o, m_bready_o,
                          resp_valid_o, resp_we_o, resp_err_o}, 9'd0);
    check("midrst_rdata", resp_rdata_o, 0);
    check("midrst_addr", m_araddr_o, 0);
    up_q.push_back(mk(1'b0, 32'h5008, 32'hCAFE_F00D, 4'h0, 2'b00, 3));
    up_q.push_back(mk(1'b1, 32'h500C, 32'h0123_4567, 4'h9, 2'b00, 3));
    drain(50);

    repeat (5) @(negedge clk_i);
    #3;
    check("exp_queue_empty", exp_q.size(), 0);
    check("pop_resp_count", n_resps, n_pops - n_aborted);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
